// File: rtl/bram_mp_pkg.sv
// rtl/bram_mp_pkg.sv - shared constants and helpers for the multi-port memory
package bram_mp_pkg;

    localparam logic [1:0] VTAG_DEFAULT = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_mp_rr_arbiter.sv
// rtl/bram_mp_rr_arbiter.sv - round-robin arbiter with one-hot combinational grant
module bram_mp_rr_arbiter
    import bram_mp_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);

    logic [PW-1:0] ptr;
    int            best;

    // Lowest rotated distance from the pointer wins; no grant while reset is held.
    always_comb begin
        grant = '0;
        gidx  = '0;
        best  = N;
        for (int k = 0; k < N; k++) begin
            if (rst && req[k] && (((k - int'(ptr) + N) % N) < best)) begin
                best = (k - int'(ptr) + N) % N;
                gidx = PW'(k);
            end
        end
        if (best < N) grant = N'(1) << gidx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= PW'((int'(gidx) + 1) % N);
        end
    end

endmodule

// File: rtl/bram_mp.sv
// rtl/bram_mp.sv - unified memory with arbitrated instruction reads, data port and video window
module bram_mp
    import bram_mp_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter int         ADDR_W = 16,
    parameter int         DEPTH  = 1024,
    parameter int         NRD    = 2,
    parameter int         VDEPTH = 512,
    parameter logic [1:0] VTAG   = VTAG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD-1:0]        ireq,
    input  logic [NRD*ADDR_W-1:0] iaddr,
    output logic [NRD-1:0]        igrant,
    output logic [NRD-1:0]        ivalid,
    output logic [NRD*DATA_W-1:0] idata,
    input  logic                  dre,
    input  logic                  dwe,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic [DATA_W-1:0]     din,
    output logic                  dvalid,
    output logic [DATA_W-1:0]     dout,
    input  logic [ADDR_W-1:0]     vaddr,
    output logic [DATA_W-1:0]     vout
);

    localparam int IW = clog2(DEPTH);
    localparam int VW = clog2(VDEPTH);
    localparam int PW = (NRD > 1) ? clog2(NRD) : 1;

    logic [DATA_W-1:0] main_mem [DEPTH];
    logic [DATA_W-1:0] vram     [VDEPTH];

    logic [PW-1:0]     gidx;
    logic [ADDR_W-1:0] g_addr;
    logic [IW-1:0]     i_idx;
    logic [IW-1:0]     w_idx;
    logic [VW-1:0]     v_ridx;
    logic [VW-1:0]     v_widx;
    logic              v_hit;
    logic [DATA_W-1:0] i_rd;
    logic [DATA_W-1:0] d_rd;
    logic [DATA_W-1:0] v_rd;

    bram_mp_rr_arbiter #(
        .N  (NRD),
        .PW (PW)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (ireq),
        .grant (igrant),
        .gidx  (gidx)
    );

    always_comb begin
        g_addr = '0;
        for (int k = 0; k < NRD; k++) begin
            if (gidx == PW'(k)) g_addr = iaddr[k*ADDR_W +: ADDR_W];
        end
    end

    assign i_idx  = g_addr[IW-1:0];
    assign w_idx  = daddr[IW-1:0];
    assign v_ridx = vaddr[VW-1:0];
    assign v_widx = daddr[VW-1:0];
    assign v_hit  = dwe && (daddr[ADDR_W-1 -: 2] == VTAG);

    // Write-first: a same-cycle write to the read index bypasses the array.
    assign i_rd = (dwe && (w_idx == i_idx)) ? din : main_mem[i_idx];
    assign d_rd = dwe ? din : main_mem[w_idx];
    assign v_rd = (v_hit && (v_widx == v_ridx)) ? din : vram[v_ridx];

    always_ff @(posedge clk) begin
        if (dwe)   main_mem[w_idx] <= din;
        if (v_hit) vram[v_widx]    <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ivalid <= '0;
            idata  <= '0;
            dvalid <= 1'b0;
            dout   <= '0;
            vout   <= '0;
        end else begin
            ivalid <= igrant;
            for (int k = 0; k < NRD; k++) begin
                if (igrant[k]) idata[k*DATA_W +: DATA_W] <= i_rd;
            end
            dvalid <= dre;
            if (dre) dout <= d_rd;
            vout <= v_rd;
        end
    end

endmodule
